// File: rtl/btn_press_classifier.sv
// Push-button conditioner: 2-flop synchroniser, debounce, and short/long press
// classification with one-cycle registered pulses.
module btn_press_classifier #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic short_p,
    output logic long_p
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG_HELD,
        DEB_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, raw_q;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               long_fired_q, long_fired_d;
    logic               level_q, level_d;
    logic               short_q, short_d;
    logic               long_q, long_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            raw_q        <= 1'b0;
            state_q      <= IDLE;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            s1_q         <= btn;
            raw_q        <= s1_q;
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            short_q      <= short_d;
            long_q       <= long_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        short_d      = 1'b0;
        long_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (raw_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!raw_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                end else if (deb_cnt_q != '1) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // Threshold wins over a simultaneous release; release is seen from LONG_HELD.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = LONG_HELD;
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end else if (!raw_q) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            LONG_HELD: begin
                long_fired_d = 1'b1;
                if (!raw_q) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                if (raw_q) begin
                    state_d = long_fired_q ? LONG_HELD : PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = IDLE;
                    short_d      = !long_fired_q;
                    long_fired_d = 1'b0;
                end else if (deb_cnt_q != '1) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        level_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == DEB_RELEASE);
    end

    assign level   = level_q;
    assign short_p = short_q;
    assign long_p  = long_q;

endmodule
